efuse_macro_ctrl: RTL and testbench



---
 rtl/efuse_pkg.sv | 25 ++
 rtl/efuse_pulse_cnt.sv | 28 ++
 rtl/efuse_macro_ctrl.sv | 173 +++++++++++++++++
 tb/tb_efuse_macro_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse macro pin controller.
// Inactive pin levels double as reset values for every macro-facing register.
package efuse_pkg;

   localparam int EFUSE_ADDR_W = 12;
   localparam int EFUSE_DATA_W = 32;
   localparam int EFUSE_CNT_W  = 10;

   localparam logic       CSN_OFF       = 1'b1;
   localparam logic       LOAD_OFF      = 1'b0;
   localparam logic       PROG_EN_N_OFF = 1'b1;
   localparam logic       STROBE_OFF    = 1'b0;
   localparam logic [1:0] MARGIN_RST    = 2'b00;

   typedef enum logic [2:0] {
      S_OFF,
      S_READ,
      S_RSTB,
      S_RSMP,
      S_PROG,
      S_PSTB,
      S_FAULT
   } efuse_ctrl_state_e;

endpackage

// File: rtl/efuse_pulse_cnt.sv
// Saturating 10-bit cycle counter with clear/enable and an equality flag.
// Shared between the read sample delay and the program-strobe watchdog.
module efuse_pulse_cnt
   import efuse_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic [EFUSE_CNT_W-1:0] i_cmp,
   output logic                   o_eq
);

   logic [EFUSE_CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_eq = (r_cnt == i_cmp);

endmodule

// File: rtl/efuse_macro_ctrl.sv
// Retimes sequencer pins onto N eFuse macro banks, captures read data after a
// programmable delay, and cuts off illegal pin combos / over-long program strobes.
//
// state   | meaning
// S_OFF   | all pins inactive, bank select tracks dest_i
// S_READ  | selected bank enabled in read (load) mode
// S_RSTB  | read strobe high
// S_RSMP  | strobe low, counting down to rdata capture
// S_PROG  | selected bank enabled in program mode
// S_PSTB  | program strobe high, watchdog running
// S_FAULT | pins inactive, sticky fault until cleared with csn released
module efuse_macro_ctrl
   import efuse_pkg::*;
#(
   parameter int N_BANKS      = 4,
   parameter int ADDR_W       = EFUSE_ADDR_W,
   parameter int DATA_W       = EFUSE_DATA_W,
   parameter int SAMPLE_DLY   = 2,
   parameter int MAX_PROG_CYC = 1023,
   localparam int DEST_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      test_mode_i,
   input  logic [DEST_W-1:0]         dest_i,
   input  logic                      csn_i,
   input  logic                      load_i,
   input  logic                      prog_en_n_i,
   input  logic                      strobe_i,
   input  logic [1:0]                read_margin_i,
   input  logic [ADDR_W-1:0]         addr_i,
   input  logic                      fault_clr_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      fault_o,
   output logic [N_BANKS-1:0]        efuse_csn_o,
   output logic                      efuse_load_o,
   output logic                      efuse_prog_en_n_o,
   output logic                      efuse_strobe_o,
   output logic [1:0]                efuse_margin_o,
   output logic [ADDR_W-1:0]         efuse_addr_o,
   input  logic [N_BANKS*DATA_W-1:0] efuse_rdata_i
);

   localparam logic [EFUSE_CNT_W-1:0] C_SMP_CMP = EFUSE_CNT_W'(SAMPLE_DLY - 1);
   localparam logic [EFUSE_CNT_W-1:0] C_WDG_CMP = EFUSE_CNT_W'(MAX_PROG_CYC - 1);

   efuse_ctrl_state_e r_state, w_state_nxt;

   logic [DEST_W-1:0]      r_bank;
   logic [DEST_W-1:0]      w_bank_sel;
   logic [N_BANKS-1:0]     r_csn, w_csn_nxt;
   logic                   r_load, r_prog_en_n, r_strobe, r_fault;
   logic [1:0]             r_margin;
   logic [ADDR_W-1:0]      r_addr;
   logic [DATA_W-1:0]      r_rdata;
   logic [DATA_W-1:0]      w_bank_rdata;
   logic                   w_cnt_clr, w_cnt_en, w_cnt_eq, w_capture;
   logic [EFUSE_CNT_W-1:0] w_cnt_cmp;
   logic                   w_hold_pins;

   efuse_pulse_cnt u_cnt (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .i_cmp (w_cnt_cmp),
      .o_eq  (w_cnt_eq)
   );

   assign w_cnt_en     = (r_state == S_RSMP) || (r_state == S_PSTB);
   assign w_cnt_cmp    = (r_state == S_PSTB) ? C_WDG_CMP : C_SMP_CMP;
   assign w_bank_sel   = (r_state == S_OFF) ? dest_i : r_bank;
   assign w_bank_rdata = efuse_rdata_i[int'(r_bank)*DATA_W +: DATA_W];
   assign w_hold_pins  = (r_state == S_RSTB) || (r_state == S_RSMP) || (r_state == S_PSTB);

   // Fault checks are ordered ahead of csn release so a bad combo is never lost.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         S_OFF: begin
            if (!csn_i) begin
               if (load_i && prog_en_n_i)       w_state_nxt = S_READ;
               else if (!load_i && !prog_en_n_i) w_state_nxt = S_PROG;
               else if (load_i && !prog_en_n_i)  w_state_nxt = S_FAULT;
            end
         end
         S_READ: begin
            if (!prog_en_n_i)  w_state_nxt = S_FAULT;
            else if (csn_i)    w_state_nxt = S_OFF;
            else if (strobe_i) w_state_nxt = S_RSTB;
         end
         S_RSTB: begin
            if (!strobe_i) begin
               w_state_nxt = S_RSMP;
               w_cnt_clr   = 1'b1;
            end
         end
         S_RSMP: begin
            if (w_cnt_eq) begin
               w_state_nxt = S_READ;
               w_capture   = 1'b1;
            end
         end
         S_PROG: begin
            if (load_i)     w_state_nxt = S_FAULT;
            else if (csn_i) w_state_nxt = S_OFF;
            else if (strobe_i && !test_mode_i) begin
               w_state_nxt = S_PSTB;
               w_cnt_clr   = 1'b1;
            end
         end
         S_PSTB: begin
            if (!strobe_i)     w_state_nxt = S_PROG;
            else if (w_cnt_eq) w_state_nxt = S_FAULT;
         end
         S_FAULT: begin
            if (fault_clr_i && csn_i) w_state_nxt = S_OFF;
         end
         default: w_state_nxt = S_OFF;
      endcase
      if (test_mode_i && (r_state != S_FAULT)) begin
         w_state_nxt = S_OFF;
         w_capture   = 1'b0;
      end
   end

   always_comb begin
      w_csn_nxt = {N_BANKS{CSN_OFF}};
      if (w_state_nxt inside {S_READ, S_RSTB, S_RSMP, S_PROG, S_PSTB})
         w_csn_nxt[w_bank_sel] = ~CSN_OFF;
   end

   // Pins are decoded from the next state so they move on the same edge as the FSM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_OFF;
         r_bank      <= '0;
         r_csn       <= {N_BANKS{CSN_OFF}};
         r_load      <= LOAD_OFF;
         r_prog_en_n <= PROG_EN_N_OFF;
         r_strobe    <= STROBE_OFF;
         r_margin    <= MARGIN_RST;
         r_addr      <= '0;
         r_rdata     <= '0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         if (r_state == S_OFF) r_bank <= dest_i;
         r_csn       <= w_csn_nxt;
         r_load      <= (w_state_nxt inside {S_READ, S_RSTB, S_RSMP}) ? ~LOAD_OFF : LOAD_OFF;
         r_prog_en_n <= (w_state_nxt inside {S_PROG, S_PSTB}) ? ~PROG_EN_N_OFF : PROG_EN_N_OFF;
         r_strobe    <= (w_state_nxt inside {S_RSTB, S_PSTB}) ? ~STROBE_OFF : STROBE_OFF;
         r_fault     <= (w_state_nxt == S_FAULT);
         if (!w_hold_pins) begin
            r_addr   <= addr_i;
            r_margin <= read_margin_i;
         end
         if (w_capture) r_rdata <= w_bank_rdata;
      end
   end

   assign rdata_o           = r_rdata;
   assign fault_o           = r_fault;
   assign efuse_csn_o       = r_csn;
   assign efuse_load_o      = r_load;
   assign efuse_prog_en_n_o = r_prog_en_n;
   assign efuse_strobe_o    = r_strobe;
   assign efuse_margin_o    = r_margin;
   assign efuse_addr_o      = r_addr;

endmodule

// File: tb/tb_efuse_macro_ctrl.sv
// Self-checking bench for efuse_macro_ctrl: expected read data is queued when a
// read is launched and popped when the sample delay elapses.
module tb_efuse_macro_ctrl;
   import efuse_pkg::*;

   localparam int N_BANKS      = 4;
   localparam int ADDR_W       = 12;
   localparam int DATA_W       = 32;
   localparam int SAMPLE_DLY   = 2;
   localparam int MAX_PROG_CYC = 16;

   logic                      clk_i = 1'b0;
   logic                      rst_i = 1'b1;
   logic                      test_mode_i = 1'b0;
   logic [1:0]                dest_i = '0;
   logic                      csn_i = 1'b1;
   logic                      load_i = 1'b0;
   logic                      prog_en_n_i = 1'b1;
   logic                      strobe_i = 1'b0;
   logic [1:0]                read_margin_i = '0;
   logic [ADDR_W-1:0]         addr_i = '0;
   logic                      fault_clr_i = 1'b0;
   logic [DATA_W-1:0]         rdata_o;
   logic                      fault_o;
   logic [N_BANKS-1:0]        efuse_csn_o;
   logic                      efuse_load_o;
   logic                      efuse_prog_en_n_o;
   logic                      efuse_strobe_o;
   logic [1:0]                efuse_margin_o;
   logic [ADDR_W-1:0]         efuse_addr_o;
   logic [N_BANKS*DATA_W-1:0] efuse_rdata_i;

   logic [DATA_W-1:0] bank_data [N_BANKS] = '{32'h1111_0000, 32'h2222_1111,
                                              32'hDEAD_BEEF, 32'h3333_4444};
   assign efuse_rdata_i = {bank_data[3], bank_data[2], bank_data[1], bank_data[0]};

   always #5 clk_i = ~clk_i;

   efuse_macro_ctrl #(
      .N_BANKS      (N_BANKS),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .SAMPLE_DLY   (SAMPLE_DLY),
      .MAX_PROG_CYC (MAX_PROG_CYC)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .test_mode_i       (test_mode_i),
      .dest_i            (dest_i),
      .csn_i             (csn_i),
      .load_i            (load_i),
      .prog_en_n_i       (prog_en_n_i),
      .strobe_i          (strobe_i),
      .read_margin_i     (read_margin_i),
      .addr_i            (addr_i),
      .fault_clr_i       (fault_clr_i),
      .rdata_o           (rdata_o),
      .fault_o           (fault_o),
      .efuse_csn_o       (efuse_csn_o),
      .efuse_load_o      (efuse_load_o),
      .efuse_prog_en_n_o (efuse_prog_en_n_o),
      .efuse_strobe_o    (efuse_strobe_o),
      .efuse_margin_o    (efuse_margin_o),
      .efuse_addr_o      (efuse_addr_o),
      .efuse_rdata_i     (efuse_rdata_i)
   );

   int                n_checks = 0;
   int                n_errors = 0;
   logic [DATA_W-1:0] sb_q [$];
   logic [DATA_W-1:0] last_rdata = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic do_read(input int bank, input logic [ADDR_W-1:0] addr,
                          input logic [1:0] margin, input int slen, input bit mid_chg);
      logic [N_BANKS-1:0] exp_csn;
      logic [DATA_W-1:0]  exp_data;
      int                 hi;
      exp_csn       = '1;
      exp_csn[bank] = 1'b0;
      dest_i        = 2'(bank);
      addr_i        = addr;
      read_margin_i = margin;
      csn_i         = 1'b0;
      load_i        = 1'b1;
      prog_en_n_i   = 1'b1;
      tick();
      chk("rd_csn", efuse_csn_o, exp_csn);
      chk("rd_load", efuse_load_o, 1'b1);
      chk("rd_addr", efuse_addr_o, addr);
      chk("rd_margin", efuse_margin_o, margin);
      sb_q.push_back(bank_data[bank]);
      strobe_i = 1'b1;
      hi = 0;
      for (int i = 0; i < slen; i++) begin
         tick();
         if (efuse_strobe_o) hi++;
         if (mid_chg) begin
            chk("rd_mid_csn", efuse_csn_o, exp_csn);
            chk("rd_mid_addr", efuse_addr_o, addr);
         end
         if (mid_chg && i == 0) begin
            dest_i = 2'd0;
            addr_i = 12'h7FF;
         end
      end
      strobe_i = 1'b0;
      tick();
      chk("rd_strobe_len", hi, slen);
      chk("rd_strobe_off", efuse_strobe_o, 1'b0);
      chk("rd_early0", rdata_o, last_rdata);
      for (int i = 1; i < SAMPLE_DLY; i++) begin
         tick();
         chk("rd_early", rdata_o, last_rdata);
      end
      tick();
      if (sb_q.size() == 0) begin
         chk("rd_sb_empty", 1, 0);
         exp_data = '0;
      end else begin
         exp_data = sb_q.pop_front();
      end
      chk("rd_data", rdata_o, exp_data);
      last_rdata = exp_data;
      if (mid_chg) begin
         chk("rd_post_addr_frozen", efuse_addr_o, addr);
         tick();
         chk("rd_post_addr_load", efuse_addr_o, 12'h7FF);
         chk("rd_post_csn", efuse_csn_o, exp_csn);
      end
      csn_i  = 1'b1;
      load_i = 1'b0;
      tick();
      chk("rd_release_csn", efuse_csn_o, 4'hF);
      chk("rd_release_load", efuse_load_o, 1'b0);
   endtask

   task automatic prog_enter(input int bank);
      logic [N_BANKS-1:0] exp_csn;
      exp_csn       = '1;
      exp_csn[bank] = 1'b0;
      dest_i        = 2'(bank);
      csn_i         = 1'b0;
      load_i        = 1'b0;
      prog_en_n_i   = 1'b0;
      tick();
      chk("pg_csn", efuse_csn_o, exp_csn);
      chk("pg_pen", efuse_prog_en_n_o, 1'b0);
   endtask

   task automatic strobe_run(input int len, output int hi);
      hi = 0;
      strobe_i = 1'b1;
      for (int i = 0; i < len; i++) begin
         tick();
         if (efuse_strobe_o) hi++;
      end
      strobe_i = 1'b0;
   endtask

   task automatic go_idle();
      csn_i       = 1'b1;
      load_i      = 1'b0;
      prog_en_n_i = 1'b1;
      strobe_i    = 1'b0;
      test_mode_i = 1'b0;
      fault_clr_i = 1'b0;
      tick();
   endtask

   initial begin
      int hi;

      tick(2);
      chk("rst_csn", efuse_csn_o, 4'hF);
      chk("rst_load", efuse_load_o, 1'b0);
      chk("rst_pen", efuse_prog_en_n_o, 1'b1);
      chk("rst_strobe", efuse_strobe_o, 1'b0);
      chk("rst_margin", efuse_margin_o, 2'b00);
      chk("rst_addr", efuse_addr_o, 12'h000);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_fault", fault_o, 1'b0);
      rst_i = 1'b0;
      tick();

      do_read(2, 12'h013, 2'b01, 5, 1'b1);
      do_read(3, 12'h2A5, 2'b10, 3, 1'b0);

      prog_enter(1);
      strobe_run(10, hi);
      tick();
      chk("pg_strobe_len", hi, 10);
      chk("pg_strobe_off", efuse_strobe_o, 1'b0);
      chk("pg_fault", fault_o, 1'b0);
      chk("pg_pen_hold", efuse_prog_en_n_o, 1'b0);

      strobe_run(40, hi);
      chk("wdg_strobe_len", hi, MAX_PROG_CYC);
      chk("wdg_fault", fault_o, 1'b1);
      chk("wdg_csn", efuse_csn_o, 4'hF);
      chk("wdg_pen", efuse_prog_en_n_o, 1'b1);
      fault_clr_i = 1'b1;
      tick();
      chk("wdg_clr_ignored", fault_o, 1'b1);
      csn_i = 1'b1;
      tick();
      chk("wdg_clr", fault_o, 1'b0);
      go_idle();

      prog_enter(3);
      test_mode_i = 1'b1;
      strobe_i    = 1'b1;
      tick();
      chk("tm_strobe", efuse_strobe_o, 1'b0);
      chk("tm_csn", efuse_csn_o, 4'hF);
      chk("tm_pen", efuse_prog_en_n_o, 1'b1);
      chk("tm_rdata", rdata_o, last_rdata);
      hi = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (efuse_strobe_o) hi++;
      end
      chk("tm_strobe_never", hi, 0);
      chk("tm_fault", fault_o, 1'b0);
      go_idle();

      dest_i      = 2'd1;
      csn_i       = 1'b0;
      load_i      = 1'b1;
      prog_en_n_i = 1'b1;
      tick();
      csn_i       = 1'b1;
      prog_en_n_i = 1'b0;
      tick();
      chk("flt_over_release", fault_o, 1'b1);
      chk("flt_csn", efuse_csn_o, 4'hF);
      prog_en_n_i = 1'b1;
      load_i      = 1'b0;
      fault_clr_i = 1'b1;
      tick();
      chk("flt_clr", fault_o, 1'b0);
      go_idle();

      prog_enter(0);
      strobe_i = 1'b1;
      tick(3);
      chk("rst_pstb_on", efuse_strobe_o, 1'b1);
      rst_i = 1'b1;
      tick();
      chk("rst_pstb_strobe", efuse_strobe_o, 1'b0);
      chk("rst_pstb_csn", efuse_csn_o, 4'hF);
      chk("rst_pstb_rdata", rdata_o, 32'h0);
      chk("rst_pstb_pen", efuse_prog_en_n_o, 1'b1);
      chk("rst_pstb_state", dut.r_state, S_OFF);
      rst_i = 1'b0;
      go_idle();

      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
